vector_mem_access: RTL and testbench

- Multi-beat vector load/store engine between the Memory stage and a 32-bit data memory port.
- Splits a 256-bit vector store into 32-bit write beats. Assembles a 256-bit vector load from 32-bit read beats.
- Holds the pipeline with a stall signal while it runs.
- Its 256-bit result is the vector read-data input to the Memory/Writeback pipeline register.

---
 rtl/vmem_pkg.sv | 9 +
 rtl/vector_lane_buffer.sv | 19 +
 rtl/vector_mem_access.sv | 75 +++++++
 tb/tb_vector_mem_access.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/vmem_pkg.sv
// vmem_pkg: shared state encoding and beat geometry for the vector load/store engine
package vmem_pkg;
  localparam int N_W = 32;
  localparam int V_W = 256;
  localparam int BEATS = V_W / N_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam int WORD_STRIDE = 4;
  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, STORE, DONE} vmem_state_t;
endpackage

// File: rtl/vector_lane_buffer.sv
// vector_lane_buffer: V-bit register written one N-bit lane at a time
module vector_lane_buffer #(
  parameter int N = 32,
  parameter int V = 256,
  parameter int LW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [LW-1:0] i_lane,
  input  logic [N-1:0]  i_data,
  output logic [V-1:0]  o_vec
);
  logic [V-1:0] r_vec;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_vec <= '0;
    else if (i_we) r_vec[i_lane*N +: N] <= i_data;
  assign o_vec = r_vec;
endmodule

// File: rtl/vector_mem_access.sv
// vector_mem_access: multi-beat vector load/store engine between the Memory stage and a word-wide memory port
module vector_mem_access
  import vmem_pkg::*;
#(
  parameter int N = N_W,
  parameter int V = V_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_load,
  input  logic         start_store,
  input  logic [N-1:0] addr,
  input  logic [V-1:0] wdata_v,
  input  logic [N-1:0] mem_rdata,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  output logic         mem_we,
  output logic         mem_re,
  output logic [V-1:0] rdata_v,
  output logic         stall,
  output logic         done
);
  localparam int NB = V / N;
  localparam int CW = $clog2(NB);
  vmem_state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_base;
  logic [V-1:0]  r_wdata;
  logic          w_start, w_last, w_lane_we;
  logic [CW-1:0] w_lane;
  logic [N-1:0]  w_beat_addr;
  assign w_start = start_load | start_store;
  assign w_last = r_cnt == CW'(NB - 1);
  assign w_beat_addr = r_base + N'(r_cnt) * N'(WORD_STRIDE);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start_store ? STORE : start_load ? LOAD : IDLE;
      LOAD:    w_next = w_last ? DRAIN : LOAD;
      DRAIN:   w_next = DONE;
      STORE:   w_next = w_last ? DONE : STORE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_base  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == LOAD || r_state == STORE) ? r_cnt + CW'(1) : '0;
      if (r_state == IDLE && w_start) r_base <= {addr[N-1:2], 2'b00};
      if (r_state == IDLE && start_store) r_wdata <= wdata_v;
    end
  assign mem_re = r_state == LOAD;
  assign mem_we = r_state == STORE;
  assign mem_addr = (mem_re | mem_we) ? w_beat_addr : '0;
  assign mem_wdata = mem_we ? r_wdata[r_cnt*N +: N] : '0;
  assign stall = (r_state == IDLE) ? w_start : (r_state != DONE);
  assign done = r_state == DONE;
  // read data trails its strobe by one cycle, so lane cnt-1 lands now and the last lane lands in DRAIN
  assign w_lane_we = (mem_re && r_cnt != '0) || r_state == DRAIN;
  assign w_lane = (r_state == DRAIN) ? CW'(NB - 1) : r_cnt - CW'(1);
  vector_lane_buffer #(.N(N), .V(V), .LW(CW)) u_rbuf (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_lane_we),
    .i_lane (w_lane),
    .i_data (mem_rdata),
    .o_vec  (rdata_v)
  );
endmodule

// File: tb/tb_vector_mem_access.sv
// tb_vector_mem_access: scoreboard bench for the vector load/store engine
module tb_vector_mem_access;
  import vmem_pkg::*;
  typedef struct packed {logic we; logic re; logic [31:0] a; logic [31:0] d;} beat_t;
  logic clk = 0, rst = 1, start_load = 0, start_store = 0;
  logic [31:0] addr = 0, mem_rdata = 0, mem_addr, mem_wdata;
  logic [255:0] wdata_v = 0, rdata_v;
  logic mem_we, mem_re, stall, done;
  int n_chk = 0, n_pass = 0;
  beat_t exp_q[$], obs_q[$];
  logic [31:0] mem [logic [31:0]];
  logic [255:0] exp_rd;

  always #5 clk = ~clk;

  vector_mem_access dut (
    .clk(clk), .rst(rst), .start_load(start_load), .start_store(start_store),
    .addr(addr), .wdata_v(wdata_v), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re), .rdata_v(rdata_v),
    .stall(stall), .done(done)
  );

  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
    if (mem_we) mem[mem_addr] = mem_wdata;
  end

  always @(negedge clk)
    if (mem_we || mem_re) obs_q.push_back({mem_we, mem_re, mem_addr, mem_wdata});

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  task automatic start_op(input logic ld, input logic st, input logic [31:0] a, input logic [255:0] d,
                          output logic req_stall);
    @(negedge clk);
    start_load = ld; start_store = st; addr = a; wdata_v = d;
    #1 req_stall = stall;
    @(posedge clk);
    #1 start_load = 0; start_store = 0;
  endtask

  task automatic wait_done(output int cyc, output int stalls);
    cyc = -1; stalls = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin cyc = i; break; end
      if (stall) stalls++;
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({mem_we, mem_re, stall, done, mem_addr, mem_wdata, rdata_v} !== '0)
      $display("FAIL reset_held: got we=%b re=%b stall=%b done=%b addr=%h rdata=%h, expected all 0", mem_we, mem_re, stall, done, mem_addr, rdata_v);
    else n_pass++;
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_chk++;
      if ({mem_we, mem_re, stall, done, mem_addr, mem_wdata, rdata_v} !== '0)
        $display("FAIL reset_idle: cycle %0d got we=%b re=%b stall=%b done=%b addr=%h wdata=%h, expected all 0", i, mem_we, mem_re, stall, done, mem_addr, mem_wdata);
      else n_pass++;
    end
  endtask

  task automatic test_load();
    logic s; int cyc, st; beat_t e, o;
    obs_q.delete();
    for (int k = 0; k < BEATS; k++) begin
      mem[32'h100 + 4*k] = 32'hA0 + k;
      exp_q.push_back({1'b0, 1'b1, 32'h100 + 32'(4*k), 32'h0});
      exp_rd[k*32 +: 32] = 32'hA0 + k;
    end
    start_op(1, 0, 32'h100, '0, s);
    n_chk++; if (s !== 1'b1) $display("FAIL load_req_stall: got %b expected 1", s); else n_pass++;
    wait_done(cyc, st);
    n_chk++; if (cyc !== 10) $display("FAIL load_latency: got %0d expected 10", cyc); else n_pass++;
    n_chk++; if (st !== 9) $display("FAIL load_stall_cycles: got %0d expected 9", st); else n_pass++;
    n_chk++; if (stall !== 1'b0) $display("FAIL load_done_stall: got %b expected 0", stall); else n_pass++;
    n_chk++; if (rdata_v !== exp_rd) $display("FAIL load_rdata: got %h expected %h", rdata_v, exp_rd); else n_pass++;
    n_chk++;
    if (obs_q.size() != exp_q.size()) $display("FAIL load_beat_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '0;
      n_chk++; if (o !== e) $display("FAIL load_beat: got %h expected %h", o, e); else n_pass++;
    end
    obs_q.delete();
  endtask

  task automatic test_store();
    logic s; int cyc, st; beat_t e, o; logic [255:0] d;
    obs_q.delete();
    for (int k = 0; k < BEATS; k++) begin
      d[k*32 +: 32] = 32'h1111_0000 + k;
      exp_q.push_back({1'b1, 1'b0, 32'h100 + 32'(4*k), 32'h1111_0000 + 32'(k)});
    end
    start_op(0, 1, 32'h100, d, s);
    n_chk++; if (s !== 1'b1) $display("FAIL store_req_stall: got %b expected 1", s); else n_pass++;
    wait_done(cyc, st);
    n_chk++; if (cyc !== 9) $display("FAIL store_latency: got %0d expected 9", cyc); else n_pass++;
    n_chk++; if (st !== 8) $display("FAIL store_stall_cycles: got %0d expected 8", st); else n_pass++;
    n_chk++; if (rdata_v !== exp_rd) $display("FAIL store_rdata_held: got %h expected %h", rdata_v, exp_rd); else n_pass++;
    n_chk++;
    if (obs_q.size() != exp_q.size()) $display("FAIL store_beat_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '0;
      n_chk++; if (o !== e) $display("FAIL store_beat: got %h expected %h", o, e); else n_pass++;
    end
    obs_q.delete();
  endtask

  task automatic test_wrap();
    logic s; int cyc, st; beat_t e, o; logic [31:0] a;
    obs_q.delete();
    for (int k = 0; k < BEATS; k++) begin
      a = 32'hFFFF_FFF0 + 32'(4*k);
      mem[a] = a ^ 32'h5A5A_5A5A;
      exp_q.push_back({1'b0, 1'b1, a, 32'h0});
      exp_rd[k*32 +: 32] = a ^ 32'h5A5A_5A5A;
    end
    start_op(1, 0, 32'hFFFF_FFF3, '0, s);
    wait_done(cyc, st);
    n_chk++; if (cyc !== 10) $display("FAIL wrap_latency: got %0d expected 10", cyc); else n_pass++;
    n_chk++; if (rdata_v !== exp_rd) $display("FAIL wrap_rdata: got %h expected %h", rdata_v, exp_rd); else n_pass++;
    n_chk++;
    if (obs_q.size() != exp_q.size()) $display("FAIL wrap_beat_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '0;
      n_chk++; if (o !== e) $display("FAIL wrap_beat: got %h expected %h", o, e); else n_pass++;
    end
    obs_q.delete();
  endtask

  task automatic test_priority();
    logic s; int cyc, st; beat_t e, o; logic [255:0] d;
    obs_q.delete();
    for (int k = 0; k < BEATS; k++) begin
      d[k*32 +: 32] = 32'hC0DE_0000 + 32'(k*3);
      exp_q.push_back({1'b1, 1'b0, 32'h300 + 32'(4*k), 32'hC0DE_0000 + 32'(k*3)});
    end
    start_op(1, 1, 32'h300, d, s);
    start_load = 1;
    wait_done(cyc, st);
    n_chk++; if (cyc !== 9) $display("FAIL prio_latency: got %0d expected 9", cyc); else n_pass++;
    @(posedge clk);
    #1 start_load = 0;
    @(negedge clk);
    n_chk++;
    if ({stall, mem_re, mem_we, done} !== 4'b0)
      $display("FAIL prio_back_idle: got stall=%b re=%b we=%b done=%b expected 0000", stall, mem_re, mem_we, done);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_chk++; if (rdata_v !== exp_rd) $display("FAIL prio_rdata_held: got %h expected %h", rdata_v, exp_rd); else n_pass++;
    n_chk++;
    if (obs_q.size() != exp_q.size()) $display("FAIL prio_beat_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '0;
      n_chk++; if (o !== e) $display("FAIL prio_beat: got %h expected %h", o, e); else n_pass++;
    end
    obs_q.delete();
  endtask

  task automatic test_reset_mid();
    logic s, saw_done; int cyc, st; beat_t e, o; logic [255:0] d;
    obs_q.delete();
    for (int k = 0; k < BEATS; k++) d[k*32 +: 32] = 32'hBEEF_0000 + k;
    for (int k = 0; k < 4; k++) exp_q.push_back({1'b1, 1'b0, 32'h400 + 32'(4*k), 32'hBEEF_0000 + 32'(k)});
    start_op(0, 1, 32'h400, d, s);
    repeat (4) @(negedge clk);
    #1 rst = 1;
    #1;
    n_chk++;
    if ({mem_we, mem_re, stall, done, mem_addr, mem_wdata, rdata_v} !== '0)
      $display("FAIL midrst_clear: got we=%b stall=%b addr=%h wdata=%h rdata=%h expected all 0", mem_we, stall, mem_addr, mem_wdata, rdata_v);
    else n_pass++;
    saw_done = 0;
    repeat (3) begin @(negedge clk); if (done || mem_we) saw_done = 1; end
    rst = 0;
    repeat (2) begin @(negedge clk); if (done || mem_we) saw_done = 1; end
    n_chk++; if (saw_done !== 1'b0) $display("FAIL midrst_no_done: got activity=%b expected 0", saw_done); else n_pass++;
    n_chk++;
    if (!mem.exists(32'h408) || mem[32'h408] !== 32'hBEEF_0002) $display("FAIL midrst_kept_beat: got exists=%b expected beat 2 written", mem.exists(32'h408));
    else n_pass++;
    n_chk++; if (mem.exists(32'h40C)) $display("FAIL midrst_aborted_beat: got exists=1 expected 0"); else n_pass++;
    n_chk++;
    if (obs_q.size() != exp_q.size()) $display("FAIL midrst_beat_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '0;
      n_chk++; if (o !== e) $display("FAIL midrst_beat: got %h expected %h", o, e); else n_pass++;
    end
    obs_q.delete();
    for (int k = 0; k < BEATS; k++) exp_rd[k*32 +: 32] = 32'h1111_0000 + k;
    start_op(1, 0, 32'h101, '0, s);
    wait_done(cyc, st);
    n_chk++; if (cyc !== 10) $display("FAIL post_rst_load_latency: got %0d expected 10", cyc); else n_pass++;
    n_chk++; if (rdata_v !== exp_rd) $display("FAIL post_rst_load_rdata: got %h expected %h", rdata_v, exp_rd); else n_pass++;
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_wrap();
    test_priority();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
